// File: rtl/riscv_pkg.sv
// ============================================================================
// Module  : riscv_pkg
// Purpose : Shared RV32I decode definitions. Holds the opcode constants, the
//           instruction-class enum, the decoded-instruction bundle and the
//           decode helper used by decode_stage.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [3:0] {
    CLS_OP      = 4'd0,
    CLS_OP_IMM  = 4'd1,
    CLS_LOAD    = 4'd2,
    CLS_STORE   = 4'd3,
    CLS_BRANCH  = 4'd4,
    CLS_LUI     = 4'd5,
    CLS_AUIPC   = 4'd6,
    CLS_JAL     = 4'd7,
    CLS_JALR    = 4'd8,
    CLS_ILLEGAL = 4'd9
  } instr_class_e;

  typedef struct packed {
    instr_class_e cls;
    logic [6:0]   opcode;
    logic [2:0]   funct3;
    logic [6:0]   funct7;
    logic [4:0]   rs1;
    logic [4:0]   rs2;
    logic [4:0]   rd;
    logic [31:0]  imm;
    logic         uses_rs1;
    logic         uses_rs2;
    logic         writes_rd;
  } decoded_t;

  // Pure field extraction and classification; no state.
  // rd is reported as 0 for classes that do not write a register so that
  // downstream consumers never see a stale destination.
  function automatic decoded_t decode_instr(input logic [31:0] instr);
    decoded_t   d;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    imm_i = {{20{instr[31]}}, instr[31:20]};
    imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    imm_u = {instr[31:12], 12'b0};
    imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    d           = '0;
    d.opcode    = instr[6:0];
    d.funct3    = instr[14:12];
    d.funct7    = instr[31:25];
    d.rs1       = instr[19:15];
    d.rs2       = instr[24:20];
    d.cls       = CLS_ILLEGAL;
    case (instr[6:0])
      OPC_OP:     begin d.cls = CLS_OP;     d.uses_rs1 = 1'b1; d.uses_rs2 = 1'b1; d.writes_rd = 1'b1; end
      OPC_OP_IMM: begin d.cls = CLS_OP_IMM; d.uses_rs1 = 1'b1; d.writes_rd = 1'b1; d.imm = imm_i; end
      OPC_LOAD:   begin d.cls = CLS_LOAD;   d.uses_rs1 = 1'b1; d.writes_rd = 1'b1; d.imm = imm_i; end
      OPC_STORE:  begin d.cls = CLS_STORE;  d.uses_rs1 = 1'b1; d.uses_rs2 = 1'b1; d.imm = imm_s; end
      OPC_BRANCH: begin d.cls = CLS_BRANCH; d.uses_rs1 = 1'b1; d.uses_rs2 = 1'b1; d.imm = imm_b; end
      OPC_LUI:    begin d.cls = CLS_LUI;    d.writes_rd = 1'b1; d.imm = imm_u; end
      OPC_AUIPC:  begin d.cls = CLS_AUIPC;  d.writes_rd = 1'b1; d.imm = imm_u; end
      OPC_JAL:    begin d.cls = CLS_JAL;    d.writes_rd = 1'b1; d.imm = imm_j; end
      OPC_JALR:   begin d.cls = CLS_JALR;   d.uses_rs1 = 1'b1; d.writes_rd = 1'b1; d.imm = imm_i; end
      default:    d.cls = CLS_ILLEGAL;
    endcase
    d.rd = d.writes_rd ? instr[11:7] : 5'd0;
    return d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/scoreboard.sv
// ============================================================================
// Module  : scoreboard
// Purpose : Register busy vector (one bit per architectural register).
//           A bit is set when a writer is issued and cleared by writeback or
//           by a flush of the held writer. Bit 0 is hard-wired clear.
// Ports   : clk, rst                  clock / synchronous active-high reset
//           set_en, set_addr          mark register busy
//           clr_wb_en, clr_wb_addr    writeback clear
//           clr_fl_en, clr_fl_addr    flush clear
//           lk_addr1..3 / lk_busy1..3 combinational lookups
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module scoreboard #(
  parameter int a_width = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               set_en,
  input  logic [a_width-1:0] set_addr,
  input  logic               clr_wb_en,
  input  logic [a_width-1:0] clr_wb_addr,
  input  logic               clr_fl_en,
  input  logic [a_width-1:0] clr_fl_addr,
  input  logic [a_width-1:0] lk_addr1,
  input  logic [a_width-1:0] lk_addr2,
  input  logic [a_width-1:0] lk_addr3,
  output logic               lk_busy1,
  output logic               lk_busy2,
  output logic               lk_busy3
);

  localparam int DEPTH = 1 << a_width;

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  // Clears first, set last: a same-cycle set of the same register wins.
  always_comb begin
    busy_d = busy_q;
    if (clr_wb_en) busy_d[clr_wb_addr] = 1'b0;
    if (clr_fl_en) busy_d[clr_fl_addr] = 1'b0;
    if (set_en)    busy_d[set_addr]    = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign lk_busy1 = busy_q[lk_addr1];
  assign lk_busy2 = busy_q[lk_addr2];
  assign lk_busy3 = busy_q[lk_addr3];

endmodule

`default_nettype wire

// File: rtl/decode_stage.sv
// ============================================================================
// Module  : decode_stage
// Purpose : RV32I decode stage with register-file read, busy-bit hazard
//           detection, one output register slice and flush support.
// Config  : DECODE_BYPASS_EN -- when defined, a same-cycle writeback is
//           forwarded into the operands instead of stalling one cycle.
// Ports   : clk, rst                         clock / sync active-high reset
//           in_valid, in_ready, in_instr     fetch-side handshake + word
//           raddr1, raddr2 / rdata1, rdata2  register-file read port
//           wb_wen, wb_waddr, wb_wdata       writeback (shared with RF write)
//           flush                            kill the held instruction
//           out_valid, out_ready             execute-side handshake
//           out_op1..out_illegal             registered decoded bundle
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module decode_stage
  import riscv_pkg::*;
#(
  parameter int d_width = 32,
  parameter int a_width = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [d_width-1:0] in_instr,
  output logic [a_width-1:0] raddr1,
  output logic [a_width-1:0] raddr2,
  input  logic [d_width-1:0] rdata1,
  input  logic [d_width-1:0] rdata2,
  input  logic               wb_wen,
  input  logic [a_width-1:0] wb_waddr,
  input  logic [d_width-1:0] wb_wdata,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [d_width-1:0] out_op1,
  output logic [d_width-1:0] out_op2,
  output logic [d_width-1:0] out_imm,
  output logic [a_width-1:0] out_rd,
  output logic [6:0]         out_opcode,
  output logic [2:0]         out_funct3,
  output logic [6:0]         out_funct7,
  output logic               out_writes_rd,
  output logic               out_illegal
);

  decoded_t dec;
  always_comb dec = decode_instr(in_instr[31:0]);

  assign raddr1 = in_instr[19:15];
  assign raddr2 = in_instr[24:20];

  logic busy_rs1, busy_rs2, busy_rd;
  logic wb_hit1, wb_hit2, wb_hit_rd;
  logic haz1, haz2, haz_rd, hazard;
  logic accept;
  logic illegal;
  logic [d_width-1:0] src1, src2;

  logic               out_valid_q,     out_valid_d;
  logic [d_width-1:0] out_op1_q,       out_op1_d;
  logic [d_width-1:0] out_op2_q,       out_op2_d;
  logic [d_width-1:0] out_imm_q,       out_imm_d;
  logic [a_width-1:0] out_rd_q,        out_rd_d;
  logic [6:0]         out_opcode_q,    out_opcode_d;
  logic [2:0]         out_funct3_q,    out_funct3_d;
  logic [6:0]         out_funct7_q,    out_funct7_d;
  logic               out_writes_rd_q, out_writes_rd_d;
  logic               out_illegal_q,   out_illegal_d;

  assign illegal   = (dec.cls == CLS_ILLEGAL);
  assign wb_hit1   = wb_wen && (wb_waddr == dec.rs1) && (dec.rs1 != '0);
  assign wb_hit2   = wb_wen && (wb_waddr == dec.rs2) && (dec.rs2 != '0);
  assign wb_hit_rd = wb_wen && (wb_waddr == dec.rd)  && (dec.rd  != '0);

`ifdef DECODE_BYPASS_EN
  // A register being written back this cycle is no longer a hazard: its
  // value is taken straight from the writeback bus.
  assign haz1   = dec.uses_rs1  && busy_rs1 && !wb_hit1;
  assign haz2   = dec.uses_rs2  && busy_rs2 && !wb_hit2;
  assign haz_rd = dec.writes_rd && busy_rd  && !wb_hit_rd;
  assign src1   = wb_hit1 ? wb_wdata : rdata1;
  assign src2   = wb_hit2 ? wb_wdata : rdata2;
`else
  // The register file is not write-through, so a source written this cycle
  // must wait one cycle for the stored value.
  logic unused_wb;
  assign unused_wb = ^{wb_wdata, wb_hit_rd};
  assign haz1   = dec.uses_rs1  && (busy_rs1 || wb_hit1);
  assign haz2   = dec.uses_rs2  && (busy_rs2 || wb_hit2);
  assign haz_rd = dec.writes_rd && busy_rd;
  assign src1   = rdata1;
  assign src2   = rdata2;
`endif

  assign hazard   = in_valid && (haz1 || haz2 || haz_rd);
  assign in_ready = !rst && !flush && !hazard && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  scoreboard #(.a_width(a_width)) u_sb (
    .clk         (clk),
    .rst         (rst),
    .set_en      (accept && dec.writes_rd && (dec.rd != '0)),
    .set_addr    (dec.rd),
    .clr_wb_en   (wb_wen && (wb_waddr != '0)),
    .clr_wb_addr (wb_waddr),
    .clr_fl_en   (flush && out_valid_q && out_writes_rd_q),
    .clr_fl_addr (out_rd_q),
    .lk_addr1    (dec.rs1),
    .lk_addr2    (dec.rs2),
    .lk_addr3    (dec.rd),
    .lk_busy1    (busy_rs1),
    .lk_busy2    (busy_rs2),
    .lk_busy3    (busy_rd)
  );

  always_comb begin
    out_valid_d     = out_valid_q;
    out_op1_d       = out_op1_q;
    out_op2_d       = out_op2_q;
    out_imm_d       = out_imm_q;
    out_rd_d        = out_rd_q;
    out_opcode_d    = out_opcode_q;
    out_funct3_d    = out_funct3_q;
    out_funct7_d    = out_funct7_q;
    out_writes_rd_d = out_writes_rd_q;
    out_illegal_d   = out_illegal_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d     = 1'b1;
      // Unused source operands are zeroed so execute never sees stale data.
      out_op1_d       = dec.uses_rs1 ? src1 : '0;
      out_op2_d       = dec.uses_rs2 ? src2 : '0;
      out_imm_d       = dec.imm;
      out_rd_d        = dec.rd;
      out_opcode_d    = dec.opcode;
      out_funct3_d    = dec.funct3;
      out_funct7_d    = dec.funct7;
      out_writes_rd_d = dec.writes_rd;
      out_illegal_d   = illegal;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q     <= 1'b0;
      out_op1_q       <= '0;
      out_op2_q       <= '0;
      out_imm_q       <= '0;
      out_rd_q        <= '0;
      out_opcode_q    <= '0;
      out_funct3_q    <= '0;
      out_funct7_q    <= '0;
      out_writes_rd_q <= 1'b0;
      out_illegal_q   <= 1'b0;
    end else begin
      out_valid_q     <= out_valid_d;
      out_op1_q       <= out_op1_d;
      out_op2_q       <= out_op2_d;
      out_imm_q       <= out_imm_d;
      out_rd_q        <= out_rd_d;
      out_opcode_q    <= out_opcode_d;
      out_funct3_q    <= out_funct3_d;
      out_funct7_q    <= out_funct7_d;
      out_writes_rd_q <= out_writes_rd_d;
      out_illegal_q   <= out_illegal_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_op1       = out_op1_q;
  assign out_op2       = out_op2_q;
  assign out_imm       = out_imm_q;
  assign out_rd        = out_rd_q;
  assign out_opcode    = out_opcode_q;
  assign out_funct3    = out_funct3_q;
  assign out_funct7    = out_funct7_q;
  assign out_writes_rd = out_writes_rd_q;
  assign out_illegal   = out_illegal_q;

endmodule

`default_nettype wire
